// File: rtl/ibus_rr_arbiter_if.sv
// Instruction-bus arbiter bundle: two requester ports plus the shared slave port.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface ibus_rr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  m0_read;
  logic [ADDR_WIDTH-1:0] m0_address;
  logic                  m0_flush;
  logic                  m0_stall;
  logic                  m0_valid;

  logic                  m1_read;
  logic [ADDR_WIDTH-1:0] m1_address;
  logic                  m1_stall;
  logic                  m1_valid;

  logic [DATA_WIDTH-1:0] m_rddata;

  logic                  s_read;
  logic [ADDR_WIDTH-1:0] s_address;
  logic                  s_stall;
  logic [DATA_WIDTH-1:0] s_rddata;

  modport master (
    input  m0_read, m0_address, m0_flush,
    output m0_stall, m0_valid,
    input  m1_read, m1_address,
    output m1_stall, m1_valid,
    output m_rddata,
    output s_read, s_address,
    input  s_stall, s_rddata
  );

  modport slave (
    output m0_read, m0_address, m0_flush,
    input  m0_stall, m0_valid,
    output m1_read, m1_address,
    input  m1_stall, m1_valid,
    input  m_rddata,
    input  s_read, s_address,
    output s_stall, s_rddata
  );
endinterface

// File: rtl/ibus_rr_arbiter.sv
// Two-requester arbiter for one pipelined instruction-bus slave with a single
// in-flight response; steers read data back and drops m0 data across a redirect.
module ibus_rr_arbiter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  ibus_rr_arbiter_if.master   bus
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  owner_e                grant;
  logic                  accept;
  logic                  resp;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] rd_data;

  logic   pipe_valid;
  owner_e pipe_owner;
  logic   pipe_drop;
  owner_e rr_last;

  // Grant depends only on requests and rr_last, so it holds steady under s_stall.
  always_comb begin
    grant = OWN_M0;
    unique case ({bus.m1_read, bus.m0_read})
      2'b10:   grant = OWN_M1;
      2'b11:   grant = FIXED_PRIORITY ? OWN_M0 : owner_e'(~rr_last);
      default: grant = OWN_M0;
    endcase
  end

  always_comb begin
    addr_sel = (grant == OWN_M1) ? bus.m1_address : bus.m0_address;
    rd_data  = bus.s_rddata;
    accept   = (bus.m0_read | bus.m1_read) & ~bus.s_stall;
    resp     = pipe_valid & ~bus.s_stall;
  end

  // Request path and response steering; a redirect in the response cycle
  // itself masks an m0 response that has not yet been marked dropped.
  always_comb begin
    bus.s_read    = bus.m0_read | bus.m1_read;
    bus.s_address = addr_sel;
    bus.m0_stall  = bus.m0_read & ~(accept & (grant == OWN_M0));
    bus.m1_stall  = bus.m1_read & ~(accept & (grant == OWN_M1));
    bus.m_rddata  = rd_data;
    bus.m0_valid  = resp & (pipe_owner == OWN_M0) & ~pipe_drop & ~bus.m0_flush;
    bus.m1_valid  = resp & (pipe_owner == OWN_M1) & ~pipe_drop;
  end

  // In-flight tracking. An accept with pipe_valid implies a response in the
  // same cycle, so a new accept simply overwrites the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_owner <= OWN_M0;
      pipe_drop  <= 1'b0;
      rr_last    <= OWN_M1;
    end else if (accept) begin
      pipe_valid <= 1'b1;
      pipe_owner <= grant;
      pipe_drop  <= 1'b0;
      rr_last    <= grant;
    end else if (resp) begin
      pipe_valid <= 1'b0;
      pipe_drop  <= 1'b0;
    end else if (pipe_valid && (pipe_owner == OWN_M0) && bus.m0_flush) begin
      pipe_drop  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibus_rr_arbiter.sv
// Directed bench for ibus_rr_arbiter: round-robin and fixed-priority instances
// driven by a one-deep slave model whose data encodes the accepted address.
module tb_ibus_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ibus_rr_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus0 ();
  ibus_rr_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus1 ();

  ibus_rr_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .FIXED_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  ibus_rr_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: returns {CAFE0000, last accepted address}.
  logic [31:0] pend0, pend1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= '0;
      pend1 <= '0;
    end else begin
      if (bus0.s_read && !bus0.s_stall) pend0 <= bus0.s_address;
      if (bus1.s_read && !bus1.s_stall) pend1 <= bus1.s_address;
    end
  end
  assign bus0.s_rddata = {32'hCAFE_0000, pend0};
  assign bus1.s_rddata = {32'hCAFE_0000, pend1};

  function automatic logic [4:0] obs0();
    return {bus0.s_read, bus0.m0_stall, bus0.m0_valid, bus0.m1_stall, bus0.m1_valid};
  endfunction

  function automatic logic [4:0] obs1();
    return {bus1.s_read, bus1.m0_stall, bus1.m0_valid, bus1.m1_stall, bus1.m1_valid};
  endfunction

  task automatic drive0(input logic m0r, input logic [31:0] m0a, input logic fl,
                        input logic m1r, input logic [31:0] m1a, input logic st);
    bus0.m0_read = m0r; bus0.m0_address = m0a; bus0.m0_flush = fl;
    bus0.m1_read = m1r; bus0.m1_address = m1a; bus0.s_stall = st;
  endtask

  task automatic drive1(input logic m0r, input logic [31:0] m0a,
                        input logic m1r, input logic [31:0] m1a);
    bus1.m0_read = m0r; bus1.m0_address = m0a; bus1.m0_flush = 1'b0;
    bus1.m1_read = m1r; bus1.m1_address = m1a; bus1.s_stall = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Flags order: {s_read, m0_stall, m0_valid, m1_stall, m1_valid}
  task automatic test_reset();
    rst_n = 1'b0;
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive1(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00000) begin
      errors++; $display("FAIL reset_rr: flags=%b want 00000", obs0());
    end
    checks++;
    if (obs1() !== 5'b00000) begin
      errors++; $display("FAIL reset_fp: flags=%b want 00000", obs1());
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00000) begin
      errors++; $display("FAIL reset_after: flags=%b want 00000", obs0());
    end
    next_cycle();
  endtask

  task automatic test_single_m0();
    drive0(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b10000 || bus0.s_address !== 32'h100) begin
      errors++; $display("FAIL single_c1: flags=%b addr=%h want 10000 00000100", obs0(), bus0.s_address);
    end
    next_cycle();
    drive0(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b10100 || bus0.s_address !== 32'h108 || bus0.m_rddata !== 64'hCAFE0000_00000100) begin
      errors++; $display("FAIL single_c2: flags=%b addr=%h data=%h want 10100 108 cafe0000_00000100", obs0(), bus0.s_address, bus0.m_rddata);
    end
    next_cycle();
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00100 || bus0.m_rddata !== 64'hCAFE0000_00000108) begin
      errors++; $display("FAIL single_c3: flags=%b data=%h want 00100 cafe0000_00000108", obs0(), bus0.m_rddata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00000) begin
      errors++; $display("FAIL single_idle: flags=%b want 00000", obs0());
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_flags;
    logic [31:0] exp_addr;
    logic [63:0] exp_data;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b0);
      exp_flags = (i == 0) ? 5'b10010 : ((i % 2 == 1) ? 5'b11100 : 5'b10011);
      exp_addr  = (i % 2 == 1) ? 32'h300 : 32'h200;
      exp_data  = (i % 2 == 1) ? 64'hCAFE0000_00000200 : 64'hCAFE0000_00000300;
      @(negedge clk);
      checks++;
      if (obs0() !== exp_flags || bus0.s_address !== exp_addr ||
          (i > 0 && bus0.m_rddata !== exp_data)) begin
        errors++; $display("FAIL rr_c%0d: flags=%b addr=%h data=%h want %b %h %h", i, obs0(), bus0.s_address, bus0.m_rddata, exp_flags, exp_addr, exp_data);
      end
      next_cycle();
    end
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00001 || bus0.m_rddata !== 64'hCAFE0000_00000300) begin
      errors++; $display("FAIL rr_tail: flags=%b data=%h want 00001 cafe0000_00000300", obs0(), bus0.m_rddata);
    end
    next_cycle();
  endtask

  task automatic test_fixed_priority();
    logic [4:0] exp_flags;
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 32'h240, 1'b1, 32'h340);
      exp_flags = (i == 0) ? 5'b10010 : 5'b10110;
      @(negedge clk);
      checks++;
      if (obs1() !== exp_flags || bus1.s_address !== 32'h240) begin
        errors++; $display("FAIL fp_c%0d: flags=%b addr=%h want %b 00000240", i, obs1(), bus1.s_address, exp_flags);
      end
      next_cycle();
    end
    drive1(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (obs1() !== 5'b00100 || bus1.m_rddata !== 64'hCAFE0000_00000240) begin
      errors++; $display("FAIL fp_tail: flags=%b data=%h want 00100 cafe0000_00000240", obs1(), bus1.m_rddata);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    drive0(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b10000) begin
      errors++; $display("FAIL stall_acc: flags=%b want 10000", obs0());
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b1);
      @(negedge clk);
      checks++;
      if (obs0() !== 5'b10010) begin
        errors++; $display("FAIL stall_c%0d: flags=%b want 10010", i, obs0());
      end
      next_cycle();
    end
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b10100 || bus0.m_rddata !== 64'hCAFE0000_00000400 || bus0.s_address !== 32'h500) begin
      errors++; $display("FAIL stall_release: flags=%b data=%h addr=%h want 10100 cafe0000_00000400 500", obs0(), bus0.m_rddata, bus0.s_address);
    end
    next_cycle();
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00001 || bus0.m_rddata !== 64'hCAFE0000_00000500) begin
      errors++; $display("FAIL stall_m1resp: flags=%b data=%h want 00001 cafe0000_00000500", obs0(), bus0.m_rddata);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    logic [4:0] exp_flags [0:4];
    exp_flags[0] = 5'b10000;  // old fetch accepted
    exp_flags[1] = 5'b11000;  // flush under stall: nothing accepted, nothing valid
    exp_flags[2] = 5'b10000;  // old response dropped, new-path fetch accepted
    exp_flags[3] = 5'b00100;  // new-path fetch returns
    exp_flags[4] = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive0(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0);
        1: drive0(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b1);
        2: drive0(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0);
        default: drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      endcase
      @(negedge clk);
      checks++;
      if (obs0() !== exp_flags[i] || (i == 3 && bus0.m_rddata !== 64'hCAFE0000_00000700)) begin
        errors++; $display("FAIL flush_c%0d: flags=%b data=%h want %b (data cafe0000_00000700 at c3)", i, obs0(), bus0.m_rddata, exp_flags[i]);
      end
      next_cycle();
    end
    // Redirect landing exactly in the response cycle.
    drive0(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00000) begin
      errors++; $display("FAIL flush_same_cycle: flags=%b want 00000", obs0());
    end
    next_cycle();
    // Redirect must not touch an m1-owned entry.
    drive0(1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b0);
    next_cycle();
    drive0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00001 || bus0.m_rddata !== 64'hCAFE0000_00000900) begin
      errors++; $display("FAIL flush_m1: flags=%b data=%h want 00001 cafe0000_00000900", obs0(), bus0.m_rddata);
    end
    next_cycle();
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    drive0(1'b1, 32'hA00, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00000) begin
      errors++; $display("FAIL midrst_during: flags=%b want 00000", obs0());
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b00000) begin
      errors++; $display("FAIL midrst_after: flags=%b want 00000", obs0());
    end
    next_cycle();
    drive0(1'b1, 32'hB00, 1'b0, 1'b1, 32'hC00, 1'b0);
    @(negedge clk);
    checks++;
    if (obs0() !== 5'b10010 || bus0.s_address !== 32'hB00) begin
      errors++; $display("FAIL midrst_tie: flags=%b addr=%h want 10010 00000b00", obs0(), bus0.s_address);
    end
    next_cycle();
    drive0(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_m0();
    test_round_robin();
    test_fixed_priority();
    test_stall();
    test_flush();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
